// File: rtl/vfu_result_wb_arbiter.sv
// rtl/vfu_result_wb_arbiter.sv - ALU/MFPU result buffering and round-robin VRF write-back arbitration

module vfu_wb_fifo #(
    parameter int unsigned Width   = 8,
    parameter int unsigned IdWidth = 1,
    parameter int unsigned Depth   = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               s_tvalid_i,
    input  logic [Width-1:0]   s_tdata_i,
    output logic               full_o,
    output logic               m_tvalid_o,
    output logic [Width-1:0]   m_tdata_o,
    input  logic               m_tready_i,
    output logic               nxt_valid_o [Depth],
    output logic [IdWidth-1:0] nxt_id_o [Depth]
);
    // A depth of 1 has no natural pointer bits, so keep one bit and wrap explicitly.
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o     = (cnt_q == CntW'(Depth));
    assign m_tvalid_o = (cnt_q != '0);
    assign m_tdata_o  = mem_q[rptr_q];
    assign push       = s_tvalid_i & ~full_o;
    assign pop        = m_tready_i & m_tvalid_o;

    always_comb begin
        mem_d  = mem_q;
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        if (push) begin
            mem_d[wptr_q] = s_tdata_i;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end

    // Occupancy after this cycle's push/pop, so the owner can register a pending view.
    always_comb begin
        logic [PtrW-1:0] off;
        for (int i = 0; i < Depth; i++) begin
            off            = PtrW'(i) - rptr_d;
            nxt_valid_o[i] = (CntW'(off) < cnt_d);
            nxt_id_o[i]    = mem_d[i][Width-1 -: IdWidth];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

module vfu_result_wb_arbiter #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned NrVInsn   = 8,
    parameter int unsigned FifoDepth = 2,
    localparam int unsigned VidWidth = (NrVInsn > 1) ? $clog2(NrVInsn) : 1,
    localparam int unsigned BeWidth  = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alu_result_req_i,
    input  logic [VidWidth-1:0]  alu_result_id_i,
    input  logic [AddrWidth-1:0] alu_result_addr_i,
    input  logic [DataWidth-1:0] alu_result_wdata_i,
    input  logic [BeWidth-1:0]   alu_result_be_i,
    output logic                 alu_result_gnt_o,
    input  logic                 mfpu_result_req_i,
    input  logic [VidWidth-1:0]  mfpu_result_id_i,
    input  logic [AddrWidth-1:0] mfpu_result_addr_i,
    input  logic [DataWidth-1:0] mfpu_result_wdata_i,
    input  logic [BeWidth-1:0]   mfpu_result_be_i,
    output logic                 mfpu_result_gnt_o,
    output logic                 vrf_req_o,
    output logic [VidWidth-1:0]  vrf_id_o,
    output logic [AddrWidth-1:0] vrf_addr_o,
    output logic [DataWidth-1:0] vrf_wdata_o,
    output logic [BeWidth-1:0]   vrf_be_o,
    output logic                 vrf_src_o,
    input  logic                 vrf_gnt_i,
    output logic [NrVInsn-1:0]   wb_pending_o
);
    localparam int unsigned EntW = VidWidth + AddrWidth + DataWidth + BeWidth;

    logic                alu_full, mfpu_full, alu_valid, mfpu_valid;
    logic                alu_pop, mfpu_pop, vrf_pop, sel;
    logic [EntW-1:0]     alu_head, mfpu_head, out_entry;
    logic                alu_nxt_valid [FifoDepth];
    logic                mfpu_nxt_valid [FifoDepth];
    logic [VidWidth-1:0] alu_nxt_id [FifoDepth];
    logic [VidWidth-1:0] mfpu_nxt_id [FifoDepth];

    logic               lock_q, lock_d, lock_src_q, lock_src_d, rr_q, rr_d;
    logic [NrVInsn-1:0] pending_q, pending_d;

    // Grants depend only on registered fullness; reset gating keeps them low while in reset.
    assign alu_result_gnt_o  = alu_result_req_i & ~alu_full & rst_ni;
    assign mfpu_result_gnt_o = mfpu_result_req_i & ~mfpu_full & rst_ni;

    vfu_wb_fifo #(.Width(EntW), .IdWidth(VidWidth), .Depth(FifoDepth)) i_alu_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .s_tvalid_i  (alu_result_gnt_o),
        .s_tdata_i   ({alu_result_id_i, alu_result_addr_i, alu_result_wdata_i, alu_result_be_i}),
        .full_o      (alu_full),
        .m_tvalid_o  (alu_valid),
        .m_tdata_o   (alu_head),
        .m_tready_i  (alu_pop),
        .nxt_valid_o (alu_nxt_valid),
        .nxt_id_o    (alu_nxt_id)
    );

    vfu_wb_fifo #(.Width(EntW), .IdWidth(VidWidth), .Depth(FifoDepth)) i_mfpu_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .s_tvalid_i  (mfpu_result_gnt_o),
        .s_tdata_i   ({mfpu_result_id_i, mfpu_result_addr_i, mfpu_result_wdata_i, mfpu_result_be_i}),
        .full_o      (mfpu_full),
        .m_tvalid_o  (mfpu_valid),
        .m_tdata_o   (mfpu_head),
        .m_tready_i  (mfpu_pop),
        .nxt_valid_o (mfpu_nxt_valid),
        .nxt_id_o    (mfpu_nxt_id)
    );

    always_comb begin
        sel = rr_q;
        if (lock_q) begin
            sel = lock_src_q;
        end else if (alu_valid && !mfpu_valid) begin
            sel = 1'b0;
        end else if (!alu_valid && mfpu_valid) begin
            sel = 1'b1;
        end
    end

    assign vrf_req_o = lock_q | alu_valid | mfpu_valid;
    assign vrf_pop   = vrf_req_o & vrf_gnt_i;
    assign alu_pop   = vrf_pop & ~sel;
    assign mfpu_pop  = vrf_pop & sel;
    assign out_entry = vrf_req_o ? (sel ? mfpu_head : alu_head) : '0;
    assign vrf_src_o = vrf_req_o & sel;
    assign {vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o} = out_entry;

    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        rr_d       = rr_q;
        if (vrf_pop) begin
            lock_d = 1'b0;
            rr_d   = ~sel;
        end else if (vrf_req_o) begin
            lock_d     = 1'b1;
            lock_src_d = sel;
        end
    end

    always_comb begin
        pending_d = '0;
        for (int i = 0; i < FifoDepth; i++) begin
            if (alu_nxt_valid[i]) pending_d[alu_nxt_id[i]] = 1'b1;
            if (mfpu_nxt_valid[i]) pending_d[mfpu_nxt_id[i]] = 1'b1;
        end
    end

    assign wb_pending_o = pending_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
            rr_q       <= 1'b0;
            pending_q  <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            rr_q       <= rr_d;
            pending_q  <= pending_d;
        end
    end
endmodule
